// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the programmable sync FIFO.
// Exports ptr_w() and the sticky error-flag bundle fifo_err_t.
package sync_fifo_pkg;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Handshake/status bundle between a FIFO and its users.
// master: producer/consumer side; slave: the FIFO itself.
interface sync_fifo_prog_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int AW = ptr_w(DEPTH);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              o_fifo_full;
    logic              o_fifo_empty;
    logic              o_almost_full;
    logic              o_almost_empty;
    logic [AW:0]       o_count;
    logic              err_clr;
    logic              o_overflow;
    logic              o_underflow;

    modport master (
        output wr_en, wr_data, rd_en, err_clr,
        input  rd_data, rd_valid,
        input  o_fifo_full, o_fifo_empty,
        input  o_almost_full, o_almost_empty,
        input  o_count, o_overflow, o_underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, err_clr,
        output rd_data, rd_valid,
        output o_fifo_full, o_fifo_empty,
        output o_almost_full, o_almost_empty,
        output o_count, o_overflow, o_underflow
    );

endinterface

// File: rtl/sync_fifo_prog_fifo_mem.sv
// FIFO storage: DEPTH x DATA_W registers, sync write, async read.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with count, almost flags, sticky errors.
// Ports: clk, rst (sync, active-high), bus (sync_fifo_prog_if.slave).
// Macro SYNC_FIFO_FWFT_EN selects first-word fall-through reads.
module sync_fifo_prog
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 4
) (
    input logic            clk,
    input logic            rst,
    sync_fifo_prog_if.slave bus
);

    localparam int AW = ptr_w(DEPTH);
    localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_AF   = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] C_AE   = (AW+1)'(AE_THRESH);
    localparam logic [AW:0] C_ONE  = (AW+1)'(1);

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and >= 4");
    end
    if (AE_THRESH >= AF_THRESH) begin : g_bad_thresh
        $error("AE_THRESH must be below AF_THRESH");
    end

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [AW:0]       count_nxt;
    logic              full_q;
    logic              empty_q;
    logic              af_q;
    logic              ae_q;
    fifo_err_t         err_q;
    fifo_err_t         err_nxt;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] mem_rd;

    assign wr_acc = bus.wr_en && !full_q;
    assign rd_acc = bus.rd_en && !empty_q;

    always_comb begin
        count_nxt = count;
        unique case (1'b1)
            wr_acc && !rd_acc: count_nxt = count + C_ONE;
            rd_acc && !wr_acc: count_nxt = count - C_ONE;
            default: ;
        endcase
    end

    // A fresh error in the clear cycle still sets the flag.
    always_comb begin
        err_nxt.overflow  = (bus.wr_en && full_q) ||
                            (err_q.overflow && !bus.err_clr);
        err_nxt.underflow = (bus.rd_en && empty_q) ||
                            (err_q.underflow && !bus.err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            err_q   <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count   <= count_nxt;
            full_q  <= (count_nxt == C_FULL);
            empty_q <= (count_nxt == '0);
            af_q    <= (count_nxt >= C_AF);
            ae_q    <= (count_nxt <= C_AE);
            err_q   <= err_nxt;
        end
    end

    fifo_mem #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (wr_acc),
        .waddr(wr_ptr),
        .wdata(bus.wr_data),
        .raddr(rd_ptr),
        .rdata(mem_rd)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.rd_data  = mem_rd;
    assign bus.rd_valid = !empty_q;
`else
    logic [DATA_W-1:0] rd_q;
    logic              rv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
            rv_q <= 1'b0;
        end else begin
            rv_q <= rd_acc;
            if (rd_acc) begin
                rd_q <= mem_rd;
            end
        end
    end

    assign bus.rd_data  = rd_q;
    assign bus.rd_valid = rv_q;
`endif

    assign bus.o_fifo_full    = full_q;
    assign bus.o_fifo_empty   = empty_q;
    assign bus.o_almost_full  = af_q;
    assign bus.o_almost_empty = ae_q;
    assign bus.o_count        = count;
    assign bus.o_overflow     = err_q.overflow;
    assign bus.o_underflow    = err_q.underflow;

endmodule
